// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: bridges exec byte read/write requests to a UART serializer/deserializer
// through TX and RX FIFOs, with one pending request per direction and sticky error flags.
module uart_io_ctrl #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    localparam int unsigned TX_AW = $clog2(TX_DEPTH),
    localparam int unsigned RX_AW = $clog2(RX_DEPTH),
    localparam int unsigned TX_LW = TX_AW + 1,
    localparam int unsigned RX_LW = RX_AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_wenable,
    input  logic [31:0]      uart_wd,
    output logic             uart_wdone,
    input  logic             uart_renable,
    output logic [31:0]      uart_rd,
    output logic             uart_rdone,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [TX_LW-1:0] tx_level,
    output logic [RX_LW-1:0] rx_level,
    output logic             rx_overrun,
    output logic             req_err
);

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LOAD   = 2'd1,
        TX_ACTIVE = 2'd2
    } tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_LW-1:0] tx_level_q, tx_level_d;
    logic             wpend_q, wpend_d;
    logic [7:0]       wpend_data_q, wpend_data_d;

    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_LW-1:0] rx_level_q, rx_level_d;
    logic             rpend_q, rpend_d;

    logic             wdone_q, wdone_d;
    logic             rdone_q, rdone_d;
    logic [31:0]      rd_q, rd_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;

    logic             tx_full, tx_empty, tx_pop, tx_push, wr_new;
    logic [7:0]       tx_push_data, tx_head;
    logic             rx_full, rx_empty, rx_pop, rx_push, rd_new, rd_wait, rx_bypass;
    logic [7:0]       rx_head;
    logic             unused_wd_hi;

    assign unused_wd_hi = ^uart_wd[31:8];

    assign tx_head  = tx_mem_q[tx_rd_ptr_q];
    assign rx_head  = rx_mem_q[rx_rd_ptr_q];
    assign tx_full  = (tx_level_q == TX_LW'(TX_DEPTH));
    assign tx_empty = (tx_level_q == '0);
    assign rx_full  = (rx_level_q == RX_LW'(RX_DEPTH));
    assign rx_empty = (rx_level_q == '0);

    // TX side: drain pop frees a slot in the same cycle for a new or pending push
    assign tx_pop       = (tx_state_q == TX_IDLE) && !tx_empty && !tx_busy;
    assign wr_new       = uart_wenable && !wpend_q;
    assign tx_push      = (wpend_q || wr_new) && (!tx_full || tx_pop);
    assign tx_push_data = wpend_q ? wpend_data_q : uart_wd[7:0];

    // RX side: a waiting read takes the incoming byte directly, bypassing the FIFO
    assign rd_new    = uart_renable && !rpend_q;
    assign rx_pop    = rd_new && !rx_empty;
    assign rd_wait   = rpend_q || (rd_new && rx_empty);
    assign rx_bypass = rd_wait && rx_valid;
    assign rx_push   = rx_valid && !rx_bypass && (!rx_full || rx_pop);

    // Next-state and registered-output logic for both paths and the drain FSM
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_wr_ptr_d  = tx_wr_ptr_q;
        tx_rd_ptr_d  = tx_rd_ptr_q;
        tx_level_d   = tx_level_q;
        wpend_d      = wpend_q;
        wpend_data_d = wpend_data_q;
        rx_wr_ptr_d  = rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_rd_ptr_q;
        rx_level_d   = rx_level_q;
        rpend_d      = rpend_q;
        wdone_d      = 1'b0;
        rdone_d      = 1'b0;
        rd_d         = rd_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        overrun_d    = overrun_q;
        err_d        = err_q;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop) begin
                    tx_state_d = TX_LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_head;
                end
            end
            TX_LOAD: begin
                if (tx_busy) begin
                    tx_state_d = TX_ACTIVE;
                end
            end
            TX_ACTIVE: begin
                if (!tx_busy) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
        end
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
            wpend_d     = 1'b0;
            wdone_d     = 1'b1;
        end else if (wr_new) begin
            wpend_d      = 1'b1;
            wpend_data_d = uart_wd[7:0];
        end
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + TX_LW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_level_d = tx_level_q - TX_LW'(1);
        end

        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
            rdone_d     = 1'b1;
            rd_d        = {24'h0, rx_head};
        end else if (rx_bypass) begin
            rdone_d = 1'b1;
            rd_d    = {24'h0, rx_data};
        end
        rpend_d = rd_wait && !rx_bypass;
        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + RX_LW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_level_d = rx_level_q - RX_LW'(1);
        end
        if (rx_valid && !rx_bypass && !rx_push) begin
            overrun_d = 1'b1;
        end

        if ((uart_wenable && wpend_q) || (uart_renable && rpend_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            tx_level_q   <= '0;
            wpend_q      <= 1'b0;
            wpend_data_q <= '0;
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            rx_level_q   <= '0;
            rpend_q      <= 1'b0;
            wdone_q      <= 1'b0;
            rdone_q      <= 1'b0;
            rd_q         <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            tx_level_q   <= tx_level_d;
            wpend_q      <= wpend_d;
            wpend_data_q <= wpend_data_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            rx_level_q   <= rx_level_d;
            rpend_q      <= rpend_d;
            wdone_q      <= wdone_d;
            rdone_q      <= rdone_d;
            rd_q         <= rd_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            overrun_q    <= overrun_d;
            err_q        <= err_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and levels
    always_ff @(posedge clk) begin
        if (!rst && tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_push_data;
        end
        if (!rst && rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data;
        end
    end

    assign uart_wdone = wdone_q;
    assign uart_rdone = rdone_q;
    assign uart_rd    = rd_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign tx_level   = tx_level_q;
    assign rx_level   = rx_level_q;
    assign rx_overrun = overrun_q;
    assign req_err    = err_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Testbench for uart_io_ctrl: directed scenarios plus randomized traffic checked every
// cycle against a queue-based behavioural model and a simple serializer model.
module tb_uart_io_ctrl;

    localparam int unsigned TXD = 16;
    localparam int unsigned RXD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_wenable;
    logic [31:0] uart_wd;
    logic        uart_wdone;
    logic        uart_renable;
    logic [31:0] uart_rd;
    logic        uart_rdone;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;
    logic        rx_overrun;
    logic        req_err;

    always #5 clk = ~clk;

    uart_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst(rst),
        .uart_wenable(uart_wenable), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
        .uart_renable(uart_renable), .uart_rd(uart_rd), .uart_rdone(uart_rdone),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_level(tx_level), .rx_level(rx_level),
        .rx_overrun(rx_overrun), .req_err(req_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    bit          m_wp;
    logic [7:0]  m_wpd;
    bit          m_rp;
    int          m_phase;    // 0 ready to start, 1 waiting for busy, 2 serializer busy
    bit          e_wdone, e_rdone, e_tx_start, e_ovr, e_err;
    logic [7:0]  e_tx_data;
    logic [31:0] e_rd;

    // Serializer model
    bit          hold_busy = 1'b0;
    int          busy_cnt = 0;
    logic [7:0]  sent[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_wp = 0; m_wpd = '0; m_rp = 0; m_phase = 0;
        e_wdone = 0; e_rdone = 0; e_tx_start = 0; e_ovr = 0; e_err = 0;
        e_tx_data = '0; e_rd = '0;
    endtask

    task automatic model_step();
        bit waiting;
        if (rst) begin
            model_reset();
            return;
        end
        e_wdone = 0; e_rdone = 0; e_tx_start = 0;
        case (m_phase)
            0: if (m_txq.size() > 0 && !tx_busy) begin
                   e_tx_start = 1;
                   e_tx_data  = m_txq.pop_front();
                   m_phase    = 1;
               end
            1: if (tx_busy) m_phase = 2;
            default: if (!tx_busy) m_phase = 0;
        endcase
        if (uart_wenable && m_wp) e_err = 1;
        if (m_wp || uart_wenable) begin
            if (m_txq.size() < TXD) begin
                m_txq.push_back(m_wp ? m_wpd : uart_wd[7:0]);
                m_wp = 0;
                e_wdone = 1;
            end else if (!m_wp) begin
                m_wp  = 1;
                m_wpd = uart_wd[7:0];
            end
        end
        if (uart_renable && m_rp) e_err = 1;
        waiting = m_rp;
        if (uart_renable && !m_rp) begin
            if (m_rxq.size() > 0) begin
                e_rd    = {24'h0, m_rxq.pop_front()};
                e_rdone = 1;
            end else begin
                waiting = 1;
            end
        end
        if (rx_valid) begin
            if (waiting) begin
                e_rd    = {24'h0, rx_data};
                e_rdone = 1;
                waiting = 0;
            end else if (m_rxq.size() < RXD) begin
                m_rxq.push_back(rx_data);
            end else begin
                e_ovr = 1;
            end
        end
        m_rp = waiting;
    endtask

    task automatic check_outputs();
        check_eq("wdone",    32'(uart_wdone), 32'(e_wdone));
        check_eq("rdone",    32'(uart_rdone), 32'(e_rdone));
        check_eq("rd",       uart_rd, e_rd);
        check_eq("tx_start", 32'(tx_start), 32'(e_tx_start));
        check_eq("tx_data",  32'(tx_data), 32'(e_tx_data));
        check_eq("tx_level", 32'(tx_level), 32'(m_txq.size()));
        check_eq("rx_level", 32'(rx_level), 32'(m_rxq.size()));
        check_eq("overrun",  32'(rx_overrun), 32'(e_ovr));
        check_eq("req_err",  32'(req_err), 32'(e_err));
    endtask

    // One clock: predict, advance, compare, then run the serializer and clear pulses
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (tx_start) sent.push_back(tx_data);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) busy_cnt = int'($urandom_range(1, 4));
        tx_busy      = hold_busy || (busy_cnt > 0);
        rst          = 1'b0;
        uart_wenable = 1'b0;
        uart_renable = 1'b0;
        rx_valid     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; uart_wenable = 0; uart_wd = '0; uart_renable = 0;
        tx_busy = 0; rx_data = '0; rx_valid = 0;
        do_reset();

        // Single write transmits promptly and the FIFO empties
        uart_wenable = 1; uart_wd = 32'hFFFF_FF41;
        step();
        check_eq("w41_wdone", 32'(uart_wdone), 32'd1);
        step();
        check_eq("w41_start", 32'(tx_start), 32'd1);
        check_eq("w41_data",  32'(tx_data), 32'h41);
        repeat (20) step();
        check_eq("w41_level", 32'(tx_level), 32'd0);

        // Fill TX while the serializer is held busy; 17th write waits for a slot
        hold_busy = 1; tx_busy = 1;
        do_reset();
        sent.delete();
        for (int i = 0; i < 16; i++) begin
            uart_wenable = 1; uart_wd = 32'(i);
            step();
        end
        check_eq("fill_level", 32'(tx_level), 32'd16);
        uart_wenable = 1; uart_wd = 32'h0000_00AA;
        step();
        check_eq("full_nodone", 32'(uart_wdone), 32'd0);
        repeat (3) step();
        hold_busy = 0; tx_busy = (busy_cnt > 0);
        step();
        check_eq("pend_wdone", 32'(uart_wdone), 32'd1);
        repeat (200) step();
        check_eq("sent_count", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 16 && i < sent.size(); i++) check_eq("sent_order", 32'(sent[i]), 32'(i));
        if (sent.size() >= 17) check_eq("sent_aa", 32'(sent[16]), 32'hAA);

        // Pending read is satisfied by the next received byte, bypassing the FIFO
        do_reset();
        uart_renable = 1;
        step();
        check_eq("rpend_nodone", 32'(uart_rdone), 32'd0);
        uart_renable = 1;
        step();
        check_eq("dup_read_err", 32'(req_err), 32'd1);
        rx_valid = 1; rx_data = 8'h5A;
        step();
        check_eq("byp_rdone", 32'(uart_rdone), 32'd1);
        check_eq("byp_rd",    uart_rd, 32'h0000_005A);
        check_eq("byp_level", 32'(rx_level), 32'd0);
        repeat (3) step();

        // RX overrun after 16 stored bytes; reads return the first 16 in order
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1; rx_data = 8'(i * 7 + 3);
            step();
        end
        check_eq("ovr_flag",  32'(rx_overrun), 32'd1);
        check_eq("ovr_level", 32'(rx_level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            uart_renable = 1;
            step();
            check_eq("ovr_read", uart_rd, 32'(8'(i * 7 + 3)));
        end

        // Simultaneous write and read both complete next cycle
        do_reset();
        rx_valid = 1; rx_data = 8'h33;
        step();
        uart_wenable = 1; uart_wd = 32'h12; uart_renable = 1;
        step();
        check_eq("both_wdone", 32'(uart_wdone), 32'd1);
        check_eq("both_rdone", 32'(uart_rdone), 32'd1);
        check_eq("both_rd",    uart_rd, 32'h33);
        repeat (10) step();

        // Reset while transmitting with a pending read discards everything
        do_reset();
        hold_busy = 1;
        uart_wenable = 1; uart_wd = 32'h66;
        hold_busy = 0;
        step();
        step();
        hold_busy = 1; tx_busy = 1;
        step();
        step();
        uart_renable = 1;
        step();
        do_reset();
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_rd",       uart_rd, 32'd0);
        rx_valid = 1; rx_data = 8'h77;
        step();
        check_eq("rst_no_rdone", 32'(uart_rdone), 32'd0);
        hold_busy = 0;
        repeat (10) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            uart_wenable = ($urandom_range(0, 99) < 30);
            uart_wd      = $urandom;
            uart_renable = ($urandom_range(0, 99) < 25);
            rx_valid     = ($urandom_range(0, 99) < 35);
            rx_data      = 8'($urandom);
            if ($urandom_range(0, 99) < 2) begin
                hold_busy = ~hold_busy;
                tx_busy   = hold_busy || (busy_cnt > 0);
            end
            rst = ($urandom_range(0, 999) < 5);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_io_ctrl.md
UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_wenable  in  1  exec write request pulse (OUTB).
REQ-006 SHALL have port uart_wd  in  32  write data; only [7:0] transmitted.
REQ-007 SHALL have port uart_wdone  out  1  one-cycle pulse: write accepted.
REQ-008 SHALL have port uart_renable  in  1  exec read request pulse (INB-class).
REQ-009 SHALL have port uart_rd  out  32  read data, {24'h0, byte}, valid while uart_rdone=1.
REQ-010 SHALL have port uart_rdone  out  1  one-cycle pulse: read data valid.
REQ-011 SHALL have port tx_data  out  8  byte to serializer, valid while tx_start=1.
REQ-012 SHALL have port tx_start  out  1  one-cycle pulse starting a transmission.
REQ-013 SHALL have port tx_busy  in  1  serializer busy.
REQ-014 SHALL have port rx_data  in  8  received byte, valid while rx_valid=1.
REQ-015 SHALL have port rx_valid  in  1  one-cycle pulse: byte received.
REQ-016 SHALL have ports tx_level/rx_level  out  log2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have ports rx_overrun, req_err  out  1 each  sticky error flags.

Function
REQ-018 Write: uart_wenable with TX FIFO not full SHALL push uart_wd[7:0] and pulse uart_wdone the next cycle.
REQ-019 Write with TX FIFO full SHALL be held pending; push occurs first cycle a slot frees, uart_wdone pulses the cycle after the push.
REQ-020 Push into a full FIFO in the same cycle as a drain pop SHALL be accepted (no pending).
REQ-021 Read: uart_renable with RX FIFO non-empty SHALL pop head and pulse uart_rdone with uart_rd next cycle.
REQ-022 Read with RX FIFO empty SHALL be held pending; the next rx_valid byte bypasses the FIFO directly to uart_rd, uart_rdone the following cycle, rx_level unchanged.
REQ-023 At most one pending write and one pending read; a new request of a kind while that kind is pending SHALL be ignored and set req_err.
REQ-024 Read and write paths SHALL be independent; both done pulses may assert in the same cycle.
REQ-025 rx_valid with RX FIFO full and no same-cycle pop/bypass SHALL drop the byte and set rx_overrun; pop and rx_valid in the same cycle on a full FIFO SHALL store the byte.
REQ-026 TX drain FSM states IDLE, LOAD, ACTIVE:
 - IDLE: FIFO non-empty and tx_busy=0 -> pulse tx_start with head byte, pop, go LOAD.
 - LOAD: tx_busy=1 -> ACTIVE; else stay.
 - ACTIVE: tx_busy=0 -> IDLE.
REQ-027 tx_start SHALL never assert outside IDLE; minimum spacing between tx_start pulses is 3 cycles.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-029 uart_rd SHALL hold its last value between pulses.

Reset
REQ-030 rst=1 SHALL, at the next edge: empty both FIFOs, clear pending flags, FSM to IDLE, uart_wdone=0, uart_rdone=0, tx_start=0, tx_data=0, uart_rd=0, levels=0, rx_overrun=0, req_err=0.
REQ-031 Reset mid-transmission or with pending requests SHALL discard them; no done pulse is issued for discarded requests.
REQ-032 Inputs SHALL be ignored while rst=1.

Verification
REQ-033 Write 0x41 with tx_busy=0 -> uart_wdone next cycle; tx_start with tx_data=0x41 within 2 cycles; tx_level returns to 0.
REQ-034 Fill TX (16 writes, tx_busy held 1), 17th write 0xAA -> no wdone; release tx_busy -> wdone one cycle after push; 0xAA later transmitted in order.
REQ-035 Read with RX empty, then rx_valid 0x5A -> uart_rdone next cycle, uart_rd=0x0000005A, rx_level=0.
REQ-036 17 rx_valid bytes with no reads -> rx_overrun=1, rx_level=16, reads return first 16 bytes in order.
REQ-037 Same-cycle write and read with both FIFOs ready -> uart_wdone and uart_rdone both pulse next cycle.
REQ-038 Assert rst during ACTIVE with pending read -> all outputs at reset values, no uart_rdone afterwards.
